topk_lane_scheduler: RTL
========================

# topk_lane_scheduler

Distributes the 33-bit word stream produced by the packet parser ({tlast, 32-bit value}) across up to 16 top-k compute lanes. Lanes are served round-robin, skipping lanes disabled in the parser's 16-bit enable mask. After the last word of a stream, every participating lane receives a one-cycle end-of-stream strobe so it can flush its result. The block sits between the parser's output FIFO and the per-lane top-k units.

## Interface
Parameters:
- NUM_LANES, 16, number of lanes; must be ≤ 16 and match the enable mask width used.
- DATA_W, 32, value width; the input word is DATA_W+1 bits wide.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  NUM_LANES  lane enable mask from the parser; sampled only at stream start.
- s_tdata  in  DATA_W+1  bit DATA_W = tlast, bits DATA_W-1:0 = value.
- s_tvalid  in  1  input word valid.
- s_tready  out  1  input word accepted when s_tvalid & s_tready.
- m_tdata  out  DATA_W  value broadcast to all lanes.
- m_tvalid  out  NUM_LANES  one-hot; identifies the destination lane.
- m_tready  in  NUM_LANES  per-lane ready.
- eos  out  NUM_LANES  one-cycle end-of-stream strobe; equals the latched mask.
- busy  out  1  high while a stream is open or the output is occupied.
- err_nolane  out  1  sticky; a word arrived while the latched mask was zero.
- word_cnt  out  32  words dispatched in the current or last stream (statistics).
- stream_cnt  out  16  completed streams since reset (statistics).

## Operation
- States:
  - LOAD: output register empty.
  - SEND: output register holds a word.
  - EOS: emit the end-of-stream strobe.
- Stream start: the first accepted word while stream_open = 0.
  - Latch `enable` into lane_mask.
  - Set the round-robin pointer so the word goes to the lowest set bit of the mask.
  - Set stream_open.
- Lane selection: each following word goes to the next set bit of lane_mask above the previous lane, wrapping from NUM_LANES-1 back to 0. With a single-bit mask, every word goes to that one lane.
- LOAD:
  - s_tready = 1.
  - On accept with lane_mask ≠ 0: load m_tdata, drive the one-hot m_tvalid, store tlast, go to SEND.
  - On accept with lane_mask = 0: drop the word and set err_nolane. If tlast, close the stream, stay in LOAD, and produce no eos.
- SEND:
  - m_tvalid is held stable until m_tready[sel] = 1.
  - s_tready = m_tready[sel] & ~cur_last. This allows back-to-back transfer: a word arriving in the same cycle is loaded and goes to the next lane.
  - On handshake with cur_last = 1: go to EOS.
  - On handshake with no new word: go to LOAD.
- EOS:
  - eos = lane_mask for exactly one cycle.
  - Clear stream_open, increment stream_cnt, go to LOAD. s_tready = 0 in this state.
- Changes to `enable` mid-stream are ignored until the next stream start.
- word_cnt clears at stream start and increments on every m_tvalid & m_tready handshake.

## Timing
- Reset values:
  - s_tready = 0 during reset, 1 in the first cycle after release.
  - m_tvalid = 0, m_tdata = 0, eos = 0, busy = 0, err_nolane = 0, word_cnt = 0, stream_cnt = 0.
  - lane_mask = 0, stream_open = 0, state LOAD.
- Latency:
  - Word accepted in cycle N → m_tvalid visible in cycle N+1.
  - Handshake of the last word in cycle N → eos high in cycle N+1 only; next word can be accepted in cycle N+2.
- Throughput: 1 word per cycle while destination lanes stay ready.
- m_tdata and m_tvalid must not change while m_tvalid ≠ 0 and m_tready[sel] = 0.
- All outputs are registered. The only combinational path is m_tready → s_tready.
- Reset asserted mid-stream:
  - Immediately clears state, mask and outputs; any held word is lost.
  - No eos is emitted.
  - err_nolane clears only on reset.

## Configuration
- TOPK_SCHED_STATS_EN:
  - Defined: word_cnt and stream_cnt counters are implemented as described (32-bit and 16-bit, wrap-around on overflow).
  - Undefined: both ports are tied to 0 and the counters are removed; dispatch behaviour is unchanged.

## Test plan
- Round-robin:
  - Stimulus: enable = 16'h0005, stream of 5 words 1..5, last with tlast, m_tready all 1.
  - Expected: lanes 0,2,0,2,0 receive 1..5 on consecutive cycles; eos = 16'h0005 for one cycle after word 5; word_cnt = 5 and stream_cnt = 1 when STATS_EN is defined.
- Backpressure:
  - Stimulus: enable = 16'h0003, m_tready[1] low for 4 cycles while word 2 targets lane 1.
  - Expected: m_tdata and m_tvalid = 16'h0002 stay stable; s_tready = 0; no loss or duplication after release.
- Mid-stream mask change:
  - Stimulus: enable = 16'h0001 at start, switched to 16'hFFFF after word 1, 3-word stream.
  - Expected: all 3 words go to lane 0; eos = 16'h0001.
- Zero mask:
  - Stimulus: enable = 0, 2-word stream with tlast on word 2.
  - Expected: words dropped; m_tvalid stays 0; err_nolane = 1; no eos; stream closes.
- Wrap and back-to-back streams:
  - Stimulus: enable = 16'h8001, stream A of 3 words then stream B of 1 word.
  - Expected: A goes to lanes 0,15,0; eos pulse; B's first word goes to lane 0; stream_cnt = 2.
- Reset mid-stream:
  - Stimulus: rst low while m_tvalid is pending.
  - Expected: all outputs return to reset values asynchronously; the next stream starts at the lowest enabled lane.

Source files
------------

// File: rtl/topk_lane_scheduler_if.sv
// Stream bundle between the parser FIFO, the lane scheduler and the top-k lanes.
// master = parser/lane side, slave = scheduler side.
interface topk_lane_scheduler_if #(
   parameter int NUM_LANES = 16,
   parameter int DATA_W    = 32
);
   logic [DATA_W:0]    s_tdata;
   logic               s_tvalid;
   logic               s_tready;
   logic [DATA_W-1:0]  m_tdata;
   logic [NUM_LANES-1:0] m_tvalid;
   logic [NUM_LANES-1:0] m_tready;

   modport master (
      output s_tdata, s_tvalid, m_tready,
      input  s_tready, m_tdata, m_tvalid
   );

   modport slave (
      input  s_tdata, s_tvalid, m_tready,
      output s_tready, m_tdata, m_tvalid
   );
endinterface

// File: rtl/topk_lane_scheduler.sv
// Round-robin word dispatcher from the parser stream to the top-k lanes.
// Optional statistics counters: define TOPK_SCHED_STATS_EN.
module topk_lane_scheduler #(
   parameter int NUM_LANES = 16,
   parameter int DATA_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_LANES-1:0] enable,
   topk_lane_scheduler_if.slave bus,
   output logic [NUM_LANES-1:0] eos,
   output logic                 busy,
   output logic                 err_nolane,
   output logic [31:0]          word_cnt,
   output logic [15:0]          stream_cnt
);
   localparam int SW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {LOAD, SEND, EOS} state_t;

   state_t               state_q, state_d;
   logic [NUM_LANES-1:0] mask_q, mask_d;
   logic                 open_q, open_d;
   logic [SW-1:0]        sel_q, sel_d;
   logic [NUM_LANES-1:0] mv_q, mv_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic                 last_q, last_d;
   logic                 err_q, err_d;
   logic [NUM_LANES-1:0] eos_q, eos_d;
   logic                 busy_q, busy_d;

   logic                 srdy, acc, hs, start;
   logic [NUM_LANES-1:0] use_mask;
   logic [SW-1:0]        prev, nxt;

   // next set bit of m strictly above p, wrapping; p = N-1 yields lowest bit
   function automatic logic [SW-1:0] next_lane(
      input logic [NUM_LANES-1:0] m,
      input logic [SW-1:0]        p
   );
      logic [SW-1:0] r;
      logic          f;
      int            idx;
      r = p;
      f = 1'b0;
      for (int i = 1; i <= NUM_LANES; i++) begin
         idx = int'(p) + i;
         if (idx >= NUM_LANES) idx = idx - NUM_LANES;
         if (!f && m[SW'(idx)]) begin
            r = SW'(idx);
            f = 1'b1;
         end
      end
      return r;
   endfunction

   // next-state, handshake and lane selection
   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      open_d   = open_q;
      sel_d    = sel_q;
      mv_d     = mv_q;
      data_d   = data_q;
      last_d   = last_q;
      err_d    = err_q;
      eos_d    = '0;
      srdy     = 1'b0;
      hs       = (state_q == SEND) & bus.m_tready[sel_q];
      unique case (state_q)
         LOAD:    srdy = 1'b1;
         SEND:    srdy = bus.m_tready[sel_q] & ~last_q;
         EOS:     srdy = 1'b0;
         default: srdy = 1'b0;
      endcase
      srdy     = srdy & rst;
      acc      = bus.s_tvalid & srdy;
      start    = acc & ~open_q;
      use_mask = open_q ? mask_q : enable;
      prev     = open_q ? sel_q : SW'(NUM_LANES - 1);
      nxt      = next_lane(use_mask, prev);
      if (hs) begin
         mv_d    = '0;
         state_d = last_q ? EOS : LOAD;
      end
      if (state_q == EOS) begin
         open_d  = 1'b0;
         state_d = LOAD;
      end
      if (acc) begin
         if (start) begin
            mask_d = enable;
            open_d = 1'b1;
         end
         if (use_mask != '0) begin
            data_d  = bus.s_tdata[DATA_W-1:0];
            mv_d    = NUM_LANES'(1) << nxt;
            sel_d   = nxt;
            last_d  = bus.s_tdata[DATA_W];
            state_d = SEND;
         end else begin
            err_d = 1'b1;
            if (bus.s_tdata[DATA_W]) open_d = 1'b0;
         end
      end
      if (state_d == EOS) eos_d = mask_q;
      busy_d = open_d | (state_d != LOAD);
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= LOAD;
         mask_q  <= '0;
         open_q  <= 1'b0;
         sel_q   <= '0;
         mv_q    <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         eos_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         open_q  <= open_d;
         sel_q   <= sel_d;
         mv_q    <= mv_d;
         data_q  <= data_d;
         last_q  <= last_d;
         err_q   <= err_d;
         eos_q   <= eos_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.s_tready = srdy;
   assign bus.m_tdata  = data_q;
   assign bus.m_tvalid = mv_q;
   assign eos          = eos_q;
   assign busy         = busy_q;
   assign err_nolane   = err_q;

`ifdef TOPK_SCHED_STATS_EN
   logic [31:0] wc_q;
   logic [15:0] sc_q;

   // per-stream word count and completed-stream count, both wrapping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wc_q <= '0;
         sc_q <= '0;
      end else begin
         if (start)   wc_q <= '0;
         else if (hs) wc_q <= wc_q + 32'd1;
         if (state_q == EOS) sc_q <= sc_q + 16'd1;
      end
   end

   assign word_cnt   = wc_q;
   assign stream_cnt = sc_q;
`else
   assign word_cnt   = '0;
   assign stream_cnt = '0;
`endif
endmodule
